// File: rtl/bpred_pkg.sv
// Shared types for the branch-prediction controller: 2-bit counter type,
// counter encodings, saturating update and the in-flight queue entry.
package bpred_pkg;

  localparam int BP_IDX_W = 4;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                pred;
  } entry_t;

  function automatic ctr_t sat_update(ctr_t ctr, logic taken);
    case (ctr)
      CTR_SNT: return taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: return taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  return taken ? CTR_ST  : CTR_WNT;
      default: return taken ? CTR_ST  : CTR_WT;
    endcase
  endfunction

endpackage

// File: rtl/bpred_inflight_fifo.sv
// In-order queue of outstanding predictions: DEPTH entries, push/pop/clear,
// with full/empty flags and an occupancy count. DEPTH must be a power of two.
module bpred_inflight_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  T                             data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output T                             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: storage is deliberately not reset; only slots below the count are
  // ever read, so clearing pointers and count is enough to empty the queue.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + 1'b1;
    else if (pop_i && !push_i) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/bpred_ctrl.sv
// Branch-prediction controller: 2-bit counter table, fetch prediction with
// resolve bypass, in-order resolution. `BPRED_GSHARE_EN adds global-history hashing.
module bpred_ctrl
  import bpred_pkg::*;
#(
  parameter int   PC_W     = 32,
  parameter int   IDX_W    = BP_IDX_W,
  parameter int   DEPTH    = 4,
  parameter ctr_t INIT_CTR = 2'd3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [PC_W-1:0]             req_pc,
  output logic                        req_ready,
  output logic                        pred_valid,
  output logic                        pred_taken,
  input  logic                        res_valid,
  input  logic                        res_taken,
  input  logic                        flush,
  output logic                        mispredict,
  output logic [$clog2(DEPTH+1)-1:0]  inflight_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  ctr_t             ctr_q [ENTRIES];
  entry_t           head, push_entry;
  logic             full, empty;
  logic             accept, resolve;
  logic [IDX_W-1:0] req_idx;
  ctr_t             upd_ctr, rd_ctr;
  logic             pred_valid_q, pred_taken_q, mispredict_q;
  logic             unused_pc;

  assign unused_pc = ^{req_pc[PC_W-1:IDX_W+2], req_pc[1:0]};

`ifdef BPRED_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  // History advances only on resolution, so it is architectural and flush-proof.
  always_ff @(posedge clk) begin
    if (rst)          ghr_q <= '0;
    else if (resolve) ghr_q <= {ghr_q[IDX_W-2:0], res_taken};
  end

  assign req_idx = req_pc[IDX_W+1:2] ^ ghr_q;
`else
  assign req_idx = req_pc[IDX_W+1:2];
`endif

  assign req_ready = !full;
  assign accept    = req_valid && req_ready && !flush;
  assign resolve   = res_valid && !empty;
  assign upd_ctr   = sat_update(ctr_q[head.idx], res_taken);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_ctr = ctr_q[req_idx];
    if (resolve && (head.idx == req_idx)) rd_ctr = upd_ctr;
  end

  assign push_entry = '{idx: req_idx, pred: rd_ctr[1]};

  // NOTE: the counter table is a small register array, so it can and must be
  // reset to INIT_CTR; a RAM macro could not be cleared this way.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_CTR;
    end else if (resolve) begin
      ctr_q[head.idx] <= upd_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      pred_valid_q <= accept;
      if (accept) pred_taken_q <= rd_ctr[1];
      mispredict_q <= resolve && (head.pred != res_taken);
    end
  end

  bpred_inflight_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (push_entry),
    .pop_i   (resolve),
    .clear_i (flush),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (inflight_cnt)
  );

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign mispredict = mispredict_q;

endmodule

// File: tb/tb_bpred_ctrl.sv
// Scoreboard bench for bpred_ctrl: a behavioural model predicts every cycle's
// outputs into queues; a negedge monitor pops and compares.
module tb_bpred_ctrl;

  localparam int PC_W  = 32;
  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam int NENT  = 1 << IDX_W;

  bit          clk;
  logic        rst, req_valid, res_valid, res_taken, flush;
  logic [31:0] req_pc;
  logic        req_ready, pred_valid, pred_taken, mispredict;
  logic [2:0]  inflight_cnt;

  int checks = 0;
  int errors = 0;

  bpred_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .INIT_CTR(2'd3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc),
    .req_ready(req_ready), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .mispredict(mispredict), .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit pred; } ent_t;
  typedef struct { bit pv; bit mis; int cnt; bit rdy; bit pt0; } stat_t;

  // Reference model state
  int   m_ctr [NENT];
  ent_t m_q [$];
  int   m_ghr;

  bit    exp_pred [$];
  stat_t exp_stat [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, wait past the edge.
  task automatic cycle(input bit r, input bit rv, input logic [31:0] pc,
                       input bit sv, input bit st, input bit fl);
    stat_t s;
    ent_t  h, e;
    int    ridx;
    bit    acc, res;
    rst = r; req_valid = rv; req_pc = pc; res_valid = sv; res_taken = st; flush = fl;
    s = '{pv: 0, mis: 0, cnt: 0, rdy: 1, pt0: 0};
    if (r) begin
      foreach (m_ctr[i]) m_ctr[i] = 3;
      m_q.delete();
      m_ghr = 0;
      s.pt0 = 1;
    end else begin
      acc  = rv && (m_q.size() != DEPTH) && !fl;
      res  = sv && (m_q.size() != 0);
      ridx = int'(pc[IDX_W+1:2]);
`ifdef BPRED_GSHARE_EN
      ridx = ridx ^ m_ghr;
`endif
      if (res) begin
        h = m_q.pop_front();
        s.mis = (h.pred != st);
        if (st) m_ctr[h.idx] = (m_ctr[h.idx] == 3) ? 3 : m_ctr[h.idx] + 1;
        else    m_ctr[h.idx] = (m_ctr[h.idx] == 0) ? 0 : m_ctr[h.idx] - 1;
        m_ghr = ((m_ghr << 1) | int'(st)) & (NENT - 1);
      end
      if (acc) begin
        e.idx  = ridx;
        e.pred = (m_ctr[ridx] >= 2);
        m_q.push_back(e);
        exp_pred.push_back(e.pred);
        s.pv = 1;
      end
      if (fl) m_q.delete();
      s.cnt = m_q.size();
      s.rdy = (m_q.size() != DEPTH);
    end
    exp_stat.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 32'h0, 0, 0, 0);
  endtask

  // Monitor: compare whatever the DUT presents after each edge.
  initial begin
    stat_t s;
    bit    p;
    forever begin
      @(negedge clk);
      if (exp_stat.size() != 0) begin
        s = exp_stat.pop_front();
        check("pred_valid", int'(pred_valid), int'(s.pv));
        check("mispredict", int'(mispredict), int'(s.mis));
        check("inflight_cnt", int'(inflight_cnt), s.cnt);
        check("req_ready", int'(req_ready), int'(s.rdy));
        if (s.pt0) check("pred_taken_reset", int'(pred_taken), 0);
      end
      if (pred_valid === 1'b1) begin
        if (exp_pred.size() == 0) begin
          check("unexpected_pred", 1, 0);
        end else begin
          p = exp_pred.pop_front();
          check("pred_taken", int'(pred_taken), int'(p));
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] pcs [4];
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h1000_0040; pcs[3] = 32'h7c;
    rst = 1; req_valid = 0; req_pc = 0; res_valid = 0; res_taken = 0; flush = 0;

    cycle(1, 0, 32'h0, 0, 0, 0);
    cycle(1, 0, 32'h0, 0, 0, 0);
    idle();

    // Basic prediction and training down to not-taken
    cycle(0, 1, 32'h40, 0, 0, 0);
    cycle(0, 1, 32'h40, 1, 0, 0);
    cycle(0, 1, 32'h40, 1, 0, 0);
    cycle(0, 0, 32'h0, 1, 0, 0);
    cycle(0, 0, 32'h0, 1, 0, 0);
    // Saturation at 0, then back up and saturation at 3
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h40, 1, 0, 0);
    cycle(0, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'h48, 1, 1, 0);
    cycle(0, 0, 32'h0, 1, 1, 0);
    idle();

    // Fill the queue, reject a fifth request, one resolve frees a slot
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'h40 + 32'(i * 4), 0, 0, 0);
    cycle(0, 1, 32'h80, 1, 1, 0);
    cycle(0, 0, 32'h0, 0, 0, 0);
    cycle(0, 1, 32'h84, 0, 0, 0);
    // Flush with a same-cycle resolve; request during flush is dropped
    cycle(0, 0, 32'h0, 1, 1, 0);
    cycle(0, 1, 32'h4c, 1, 0, 1);
    cycle(0, 0, 32'h0, 1, 1, 0);
    cycle(0, 1, 32'h40, 0, 0, 0);
    cycle(0, 0, 32'h0, 1, 0, 0);
    idle();

    // Randomised traffic with occasional flush and mid-run reset
    for (int n = 0; n < 4000; n++) begin
      pc = ($urandom_range(0, 1) == 1) ? pcs[$urandom_range(0, 3)] : $urandom;
      cycle(($urandom_range(0, 499) == 0),
            ($urandom_range(0, 9) < 6), pc,
            ($urandom_range(0, 9) < 5), $urandom_range(0, 1),
            ($urandom_range(0, 39) == 0));
    end

    idle();
    idle();
    @(negedge clk);
    #1;
    check("exp_stat_drained", exp_stat.size(), 0);
    check("exp_pred_drained", exp_pred.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpred_ctrl.md
Name: bpred_ctrl

Overview:
Branch-prediction controller sitting between fetch and the resolve stage. Holds a table of 2-bit saturating counters indexed by PC, and answers fetch prediction requests. Tracks outstanding predictions in an in-order in-flight queue, so that each later resolution updates the correct counter and raises mispredict. Sequences and shares the counter table between the fetch (read) and resolve (update) requesters.

Parameters:
PC_W, 32, fetch PC width
IDX_W, 4, table index width; table holds 2**IDX_W entries
DEPTH, 4, maximum outstanding (unresolved) predictions; power of two
INIT_CTR, 2'd3, counter reset value (strongly taken)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  fetch requests a prediction
req_pc  in  PC_W  PC of the branch
req_ready  out  1  request can be accepted (queue not full)
pred_valid  out  1  prediction valid, one cycle after acceptance
pred_taken  out  1  predicted direction
res_valid  in  1  resolution of the oldest outstanding branch
res_taken  in  1  actual direction
flush  in  1  discard all outstanding predictions
mispredict  out  1  registered; previous resolution disagreed with its prediction
inflight_cnt  out  $clog2(DEPTH+1)  outstanding predictions

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - All counters = INIT_CTR; queue empty; inflight_cnt = 0.
  - pred_valid = 0, pred_taken = 0, mispredict = 0, req_ready = 1.
  - Reset mid-operation drops every queued entry silently.
- Index: idx = req_pc[IDX_W+1:2]; bits [1:0] are ignored.
- req_ready = (inflight_cnt != DEPTH). It is combinational from the registered count and does not account for a same-cycle pop.
- Accept = req_valid && req_ready && !flush. On accept:
  - Next cycle, pred_valid = 1 and pred_taken = ctr[idx][1].
  - Push {idx, pred_taken} into the queue.
  - Otherwise pred_valid = 0 next cycle, and pred_taken holds its last value.
- Read/update hazard: if a resolution updates the same idx in the accept cycle, the prediction uses the post-update counter (bypass).
- Resolve, when res_valid and the queue is non-empty:
  - Pop the head.
  - Counter update: +1 if res_taken, saturating at 3; -1 if not taken, saturating at 0.
  - Next cycle, mispredict = (head.pred != res_taken). mispredict is a one-cycle pulse.
- res_valid with the queue empty: ignored. No counter change, mispredict = 0.
- Simultaneous accept and resolve: both happen; inflight_cnt is unchanged.
- flush: the same-cycle resolution (if any) is applied first, then the queue is cleared; inflight_cnt = 0 next cycle. A request presented during flush is not accepted. Counters are never reset by flush.
- Pointers wrap modulo DEPTH. Queue depth is exactly DEPTH; there is no pass-through when full.
- Latency: prediction 1 cycle; counter update visible to requests 0 cycles later (bypass); mispredict 1 cycle after res_valid.

Optional Feature:
BPRED_GSHARE_EN:
- Defined:
  - Add an IDX_W-bit global history register, reset 0.
  - idx = req_pc[IDX_W+1:2] ^ ghr.
  - On each resolve, ghr = {ghr[IDX_W-2:0], res_taken}. It is non-speculative and not affected by flush.
  - The queue stores the hashed idx, so an update always hits the entry that produced the prediction.
- Undefined: plain bimodal indexing; no ghr logic is present.

Decomposition:
- Shared package bpred_pkg holds:
  - ctr_t (2-bit).
  - Constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - Function sat_update(ctr_t, taken).
  - The queue entry struct {idx, pred}.
- Natural sub-module: bpred_inflight_fifo. A synchronous FIFO of DEPTH entries with push, pop, clear, full/empty and count. bpred_ctrl holds the counter table and bypass logic.

Test Plan:
- Reset, then request pc=0x40 → pred_valid=1 next cycle, pred_taken=1 (counter=3); inflight_cnt=1.
- Same pc, resolve not-taken twice (requesting each time) → predictions 1, 1, then a third request predicts 0; mispredict pulses after each of the first two resolves.
- Counter already 0 and resolved not-taken again → counter stays 0 (no wrap to 3). Counter at 3 resolved taken → stays 3.
- Issue DEPTH=4 requests without resolving → req_ready=0 and a 5th req_valid is not accepted. One resolve drops the count to 3, and req_ready=1 the following cycle.
- With 3 outstanding, assert flush together with res_valid=1 and res_taken=0 → head counter decremented, inflight_cnt=0 next cycle. A later res_valid with an empty queue produces no counter change and mispredict=0.
- BPRED_GSHARE_EN:
  - After resolving taken, taken, the ghr is 0b0011.
  - A request with pc=0x40 (idx 0) then reads entry 3, and its resolution updates entry 3, not entry 0.
